// File: rtl/sw_ctrl_unit.sv
// UART stopwatch control unit: arbitrates button and UART commands, runs the
// STOP/RUN/CLEAR sequencer, drives the FND display mode and returns UART acks.
module sw_ctrl_unit #(
    parameter int          CLEAR_CYCLES = 4,
    parameter logic [7:0]  ACK_UNKNOWN  = 8'h3F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_clear,
    input  logic       btn_mode,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_busy,
    output logic       o_run,
    output logic       o_clear,
    output logic [1:0] o_mode,
    output logic       tx_start,
    output logic [7:0] tx_data
);

    typedef enum logic [1:0] {EVT_NONE, EVT_RUN, EVT_CLR, EVT_MODE} evt_t;
    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_CLEAR} state_t;

    state_t     state_reg, state_next;
    logic [3:0] clr_cnt_reg, clr_cnt_next;
    logic       mode_bit_reg;
    logic       uart_valid_reg;
    evt_t       uart_evt_reg;
    logic       ack_valid_reg;
    logic [7:0] ack_byte_reg;
    logic       tx_start_reg;
    logic [7:0] tx_data_reg;

    evt_t       rx_evt;
    logic [7:0] rx_ack;
    evt_t       evt;
    logic       btn_any;
    logic       uart_consume;
    logic       ack_send;

    always_comb begin
        rx_evt = EVT_NONE;
        rx_ack = ACK_UNKNOWN;
        case (rx_data)
            8'h52, 8'h72: begin rx_evt = EVT_RUN;  rx_ack = 8'h52; end
            8'h43, 8'h63: begin rx_evt = EVT_CLR;  rx_ack = 8'h43; end
            8'h4D, 8'h6D: begin rx_evt = EVT_MODE; rx_ack = 8'h4D; end
            default:      begin rx_evt = EVT_NONE; rx_ack = ACK_UNKNOWN; end
        endcase
    end

    // Buttons win; the UART slot waits for the first button-free cycle.
    always_comb begin
        btn_any      = btn_run | btn_clear | btn_mode;
        uart_consume = !btn_any && uart_valid_reg;
        if (btn_clear)           evt = EVT_CLR;
        else if (btn_run)        evt = EVT_RUN;
        else if (btn_mode)       evt = EVT_MODE;
        else if (uart_valid_reg) evt = uart_evt_reg;
        else                     evt = EVT_NONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_STOP;
            clr_cnt_reg <= 4'd0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            ST_STOP: begin
                if (evt == EVT_RUN) begin
                    state_next = ST_RUN;
                end else if (evt == EVT_CLR) begin
                    state_next   = ST_CLEAR;
                    clr_cnt_next = 4'(CLEAR_CYCLES - 1);
                end
            end
            ST_RUN: begin
                if (evt == EVT_RUN) state_next = ST_STOP;
            end
            ST_CLEAR: begin
                if (clr_cnt_reg == 4'd0) state_next = ST_STOP;
                else                     clr_cnt_next = clr_cnt_reg - 4'd1;
            end
            default: state_next = ST_STOP;
        endcase
    end

    always_comb begin
        o_run   = (state_reg == ST_RUN);
        o_clear = (state_reg == ST_CLEAR);
        o_mode  = {1'b0, mode_bit_reg};
    end

    // A new ack written on the same edge as a send survives for the next send.
    assign ack_send = ack_valid_reg && !tx_busy && !tx_start_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_bit_reg   <= 1'b0;
            uart_valid_reg <= 1'b0;
            uart_evt_reg   <= EVT_NONE;
            ack_valid_reg  <= 1'b0;
            ack_byte_reg   <= 8'h00;
            tx_start_reg   <= 1'b0;
            tx_data_reg    <= 8'h00;
        end else begin
            if (evt == EVT_MODE) mode_bit_reg <= ~mode_bit_reg;
            if (rx_done) begin
                uart_valid_reg <= (rx_evt != EVT_NONE);
                uart_evt_reg   <= rx_evt;
            end else if (uart_consume) begin
                uart_valid_reg <= 1'b0;
            end
            if (rx_done) begin
                ack_valid_reg <= 1'b1;
                ack_byte_reg  <= rx_ack;
            end else if (ack_send) begin
                ack_valid_reg <= 1'b0;
            end
            tx_start_reg <= ack_send;
            if (ack_send) tx_data_reg <= ack_byte_reg;
        end
    end

    assign tx_start = tx_start_reg;
    assign tx_data  = tx_data_reg;

endmodule

// File: tb/tb_sw_ctrl_unit.sv
// Self-checking bench for sw_ctrl_unit: per-feature tasks plus an ack scoreboard.
module tb_sw_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_run = 1'b0, btn_clear = 1'b0, btn_mode = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       tx_busy = 1'b0;
    logic       o_run, o_clear, tx_start;
    logic [1:0] o_mode;
    logic [7:0] tx_data;

    int tests_run = 0;
    int tests_failed = 0;
    int tx_count = 0;
    logic prev_start = 1'b0;
    logic [7:0] ack_q[$];

    sw_ctrl_unit #(.CLEAR_CYCLES(4), .ACK_UNKNOWN(8'h3F)) dut (
        .clk(clk), .rst(rst),
        .btn_run(btn_run), .btn_clear(btn_clear), .btn_mode(btn_mode),
        .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
        .o_run(o_run), .o_clear(o_clear), .o_mode(o_mode),
        .tx_start(tx_start), .tx_data(tx_data)
    );

    always #5 clk = ~clk;

    // Ack monitor: every tx_start pops the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0;
        end else begin
            if (tx_start === 1'b1) begin
                tx_count++;
                tests_run++;
                if (ack_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL tx_unexpected: tx_start with tx_data=%h, none expected", tx_data);
                end else begin
                    logic [7:0] exp_b;
                    exp_b = ack_q.pop_front();
                    if (tx_data !== exp_b) begin
                        tests_failed++;
                        $display("FAIL tx_data: got %h expected %h", tx_data, exp_b);
                    end else begin
                        $display("[TB] ack sent %h", tx_data);
                    end
                end
                tests_run++;
                if (prev_start === 1'b1) begin
                    tests_failed++;
                    $display("FAIL tx_back_to_back: tx_start high on two consecutive cycles");
                end
            end
            prev_start = tx_start;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic r, input logic c, input logic m,
                         input logic rd, input logic [7:0] b);
        btn_run = r; btn_clear = c; btn_mode = m; rx_done = rd; rx_data = b;
        cyc();
        btn_run = 0; btn_clear = 0; btn_mode = 0; rx_done = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cyc();
        tests_run += 5;
        if (o_run !== 1'b0)    begin tests_failed++; $display("FAIL reset_run: got %b expected 0", o_run); end
        if (o_clear !== 1'b0)  begin tests_failed++; $display("FAIL reset_clear: got %b expected 0", o_clear); end
        if (o_mode !== 2'b00)  begin tests_failed++; $display("FAIL reset_mode: got %b expected 00", o_mode); end
        if (tx_start !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        rst = 1'b0;
        cyc();
        $display("[TB] reset checked");
    endtask

    task automatic test_run_stop();
        pulse(1, 0, 0, 0, 8'h00);
        tests_run += 2;
        if (o_run !== 1'b1)   begin tests_failed++; $display("FAIL run_start: got %b expected 1", o_run); end
        if (o_mode !== 2'b00) begin tests_failed++; $display("FAIL run_mode: got %b expected 00", o_mode); end
        pulse(1, 0, 0, 0, 8'h00);
        tests_run += 2;
        if (o_run !== 1'b0)   begin tests_failed++; $display("FAIL run_stop: got %b expected 0", o_run); end
        if (o_mode !== 2'b00) begin tests_failed++; $display("FAIL stop_mode: got %b expected 00", o_mode); end
        $display("[TB] button run/stop checked");
    endtask

    task automatic test_uart_clear();
        ack_q.push_back(8'h43);
        pulse(0, 0, 0, 1, 8'h63);
        tests_run++;
        if (o_clear !== 1'b0) begin tests_failed++; $display("FAIL clear_early: got %b expected 0 at N+1", o_clear); end
        cyc();
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (o_clear !== 1'b1) begin tests_failed++; $display("FAIL clear_hold%0d: got %b expected 1", i, o_clear); end
            cyc();
        end
        tests_run += 2;
        if (o_clear !== 1'b0) begin tests_failed++; $display("FAIL clear_end: got %b expected 0", o_clear); end
        if (o_run !== 1'b0)   begin tests_failed++; $display("FAIL clear_run: got %b expected 0", o_run); end
        repeat (3) cyc();
        tests_run++;
        if (ack_q.size() != 0) begin tests_failed++; $display("FAIL clear_ack_pending: got %0d expected 0", ack_q.size()); end
        $display("[TB] uart clear checked");
    endtask

    task automatic test_run_buttons();
        pulse(1, 0, 0, 0, 8'h00);
        pulse(0, 1, 0, 0, 8'h00);
        tests_run += 2;
        if (o_run !== 1'b1)   begin tests_failed++; $display("FAIL run_clear_run: got %b expected 1", o_run); end
        if (o_clear !== 1'b0) begin tests_failed++; $display("FAIL run_clear_clear: got %b expected 0", o_clear); end
        pulse(0, 0, 1, 0, 8'h00);
        tests_run++;
        if (o_mode !== 2'b01) begin tests_failed++; $display("FAIL mode_toggle1: got %b expected 01", o_mode); end
        pulse(0, 0, 1, 0, 8'h00);
        tests_run++;
        if (o_mode !== 2'b00) begin tests_failed++; $display("FAIL mode_toggle2: got %b expected 00", o_mode); end
        pulse(1, 0, 0, 0, 8'h00);
        // All three buttons from STOP: clear wins, run and mode dropped.
        pulse(1, 1, 1, 0, 8'h00);
        tests_run += 3;
        if (o_clear !== 1'b1) begin tests_failed++; $display("FAIL prio_clear: got %b expected 1", o_clear); end
        if (o_run !== 1'b0)   begin tests_failed++; $display("FAIL prio_run: got %b expected 0", o_run); end
        if (o_mode !== 2'b00) begin tests_failed++; $display("FAIL prio_mode: got %b expected 00", o_mode); end
        repeat (5) cyc();
        $display("[TB] run-state buttons and priority checked");
    endtask

    task automatic test_same_cycle();
        ack_q.push_back(8'h52);
        pulse(0, 0, 1, 1, 8'h52);
        tests_run += 2;
        if (o_mode !== 2'b01) begin tests_failed++; $display("FAIL same_mode: got %b expected 01", o_mode); end
        if (o_run !== 1'b0)   begin tests_failed++; $display("FAIL same_run_early: got %b expected 0", o_run); end
        cyc();
        tests_run++;
        if (o_run !== 1'b1)   begin tests_failed++; $display("FAIL same_run: got %b expected 1", o_run); end
        repeat (3) cyc();
        pulse(1, 0, 0, 0, 8'h00);
        pulse(0, 0, 1, 0, 8'h00);
        tests_run++;
        if (ack_q.size() != 0) begin tests_failed++; $display("FAIL same_ack_pending: got %0d expected 0", ack_q.size()); end
        $display("[TB] button+uart same cycle checked");
    endtask

    task automatic test_busy();
        int cnt0;
        cnt0 = tx_count;
        tx_busy = 1'b1;
        pulse(0, 0, 0, 1, 8'h78);
        pulse(0, 0, 0, 1, 8'h4D);
        repeat (6) cyc();
        tests_run += 2;
        if (tx_count != cnt0) begin tests_failed++; $display("FAIL busy_hold: got %0d starts expected %0d", tx_count, cnt0); end
        if (o_mode !== 2'b01) begin tests_failed++; $display("FAIL busy_mode: got %b expected 01", o_mode); end
        ack_q.push_back(8'h4D);
        tx_busy = 1'b0;
        repeat (5) cyc();
        tests_run++;
        if (tx_count != cnt0 + 1) begin tests_failed++; $display("FAIL busy_release: got %0d starts expected %0d", tx_count, cnt0 + 1); end
        pulse(0, 0, 1, 0, 8'h00);
        $display("[TB] tx_busy overwrite checked");
    endtask

    task automatic test_back_to_back();
        ack_q.push_back(8'h52);
        ack_q.push_back(8'h52);
        pulse(0, 0, 0, 1, 8'h72);
        pulse(0, 0, 0, 1, 8'h72);
        tests_run++;
        if (o_run !== 1'b1) begin tests_failed++; $display("FAIL b2b_run: got %b expected 1", o_run); end
        cyc();
        tests_run++;
        if (o_run !== 1'b0) begin tests_failed++; $display("FAIL b2b_stop: got %b expected 0", o_run); end
        repeat (6) cyc();
        tests_run++;
        if (ack_q.size() != 0) begin tests_failed++; $display("FAIL b2b_ack_pending: got %0d expected 0", ack_q.size()); end
        $display("[TB] back-to-back bytes checked");
    endtask

    task automatic test_reset_mid();
        int cnt0;
        cnt0 = tx_count;
        tx_busy = 1'b1;
        pulse(0, 0, 0, 1, 8'h4D);
        pulse(0, 1, 0, 0, 8'h00);
        cyc();
        tests_run += 2;
        if (o_clear !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_clear: got %b expected 1", o_clear); end
        if (o_mode !== 2'b01) begin tests_failed++; $display("FAIL mid_pre_mode: got %b expected 01", o_mode); end
        rst = 1'b1;
        #1;
        tests_run += 3;
        if (o_clear !== 1'b0) begin tests_failed++; $display("FAIL mid_clear: got %b expected 0", o_clear); end
        if (o_run !== 1'b0)   begin tests_failed++; $display("FAIL mid_run: got %b expected 0", o_run); end
        if (o_mode !== 2'b00) begin tests_failed++; $display("FAIL mid_mode: got %b expected 00", o_mode); end
        repeat (2) cyc();
        rst = 1'b0;
        tx_busy = 1'b0;
        repeat (8) cyc();
        tests_run += 2;
        if (tx_count != cnt0) begin tests_failed++; $display("FAIL mid_ack_dropped: got %0d starts expected %0d", tx_count, cnt0); end
        if (o_clear !== 1'b0) begin tests_failed++; $display("FAIL mid_after_clear: got %b expected 0", o_clear); end
        $display("[TB] reset during clear checked");
    endtask

    initial begin
        test_reset();
        test_run_stop();
        test_uart_clear();
        test_run_buttons();
        test_same_cycle();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sw_ctrl_unit.md
Name: sw_ctrl_unit

Overview:
- Control unit for the UART stopwatch. Arbitrates run/stop, clear and display-mode commands from the debounced board buttons and from UART RX bytes.
- Sequences the stopwatch datapath through a STOP/RUN/CLEAR state machine and drives the `mode` input of the FND controller.
- Returns a one-byte UART acknowledge for every received byte.

Parameters:
- CLEAR_CYCLES, 4, number of clk cycles `o_clear` is held high per clear (range 1..15).
- ACK_UNKNOWN, 8'h3F, byte returned for an unrecognised RX byte ('?').

Ports:
- clk  input  1  system clock (100 MHz)
- rst  input  1  asynchronous, active-high reset
- btn_run  input  1  run/stop request, one-cycle pulse (debounced upstream)
- btn_clear  input  1  clear request, one-cycle pulse
- btn_mode  input  1  display-mode toggle request, one-cycle pulse
- rx_data  input  8  received UART byte, valid when rx_done=1
- rx_done  input  1  one-cycle pulse, new RX byte
- tx_busy  input  1  UART TX busy; tx_start is ignored by the TX while high
- o_run  output  1  1 = stopwatch counting
- o_clear  output  1  1 = stopwatch counter held at zero
- o_mode  output  2  display mode to FND controller; bit0 = 0 msec:sec, 1 min:hour; bit1 is always 0
- tx_start  output  1  one-cycle pulse, start ack transmission
- tx_data  output  8  ack byte; stable from the tx_start cycle until the next tx_start

Behaviour:
- Reset (async, any state): state=STOP, o_run=0, o_clear=0, o_mode=2'b00, tx_start=0, tx_data=8'h00, UART pending slot empty, ack slot empty, clear counter=0.
- RX decode, registered into a one-entry UART pending slot on rx_done:
  - 'R'/'r' -> RUN_EVT, ack 8'h52.
  - 'C'/'c' -> CLR_EVT, ack 8'h43.
  - 'M'/'m' -> MODE_EVT, ack 8'h4D.
  - Any other byte -> no event, ack = ACK_UNKNOWN.
  - If rx_done arrives while the slot is still occupied, the new byte overwrites it.
- Arbitration, one event consumed per cycle:
  - A button pulse has priority over the UART pending slot.
  - If any button pulse is present, the UART slot is held and consumed on the first cycle with no button pulse.
  - Among simultaneous buttons, priority is clear > run > mode. The lower-priority button pulses are dropped.
- FSM (states STOP, RUN, CLEAR):
  - STOP + RUN_EVT -> RUN.
  - STOP + CLR_EVT -> CLEAR, clear counter loaded with CLEAR_CYCLES-1.
  - RUN + RUN_EVT -> STOP.
  - RUN + CLR_EVT -> ignored (consumed, no effect).
  - CLEAR: counter decrements each cycle; at 0 -> STOP. RUN_EVT and CLR_EVT are consumed and ignored.
  - MODE_EVT toggles o_mode[0] in every state.
- Outputs are registered and take effect one cycle after the event is consumed:
  - o_run = (state==RUN).
  - o_clear = (state==CLEAR); it is high for exactly CLEAR_CYCLES consecutive cycles.
- Latency: button pulse at cycle N -> o_run/o_clear/o_mode change at N+1. A UART byte with no competing button: rx_done at N -> slot valid at N+1 -> outputs change at N+2.
- Ack handshake:
  - The ack byte is written into a one-entry ack slot when its RX byte is decoded; button events produce no ack.
  - When the slot is full and tx_busy=0: tx_start=1 for one cycle, tx_data=slot byte, slot cleared in the same cycle.
  - While tx_busy=1 the slot is held. A newer ack overwrites an unsent one; only the latest is sent.
  - tx_start is never asserted on two consecutive cycles.
- Reset asserted mid-CLEAR or mid-ack: everything returns immediately to reset values; pending events and acks are discarded.

Test Plan:
- Reset, then btn_run pulse -> o_run=1 next cycle; second btn_run -> o_run=0; o_mode stays 2'b00 throughout.
- From STOP, rx byte 8'h63 ('c') with tx_busy=0 -> o_clear high exactly 4 cycles (CLEAR_CYCLES=4), starting 2 cycles after rx_done, then state=STOP; tx_start pulse with tx_data=8'h43.
- In RUN, btn_clear pulse -> o_run stays 1, o_clear stays 0; btn_mode -> o_mode=2'b01; second btn_mode -> 2'b00.
- rx_done with 'R' in the same cycle as btn_mode -> o_mode toggles at N+1, o_run=1 at N+2; ack 8'h52 sent.
- tx_busy=1 while bytes 'x' then 'M' arrive -> no tx_start while busy; after tx_busy falls, exactly one tx_start with tx_data=8'h4D; o_mode toggled once.
- Assert rst during cycle 2 of CLEAR with an ack pending -> o_clear=0, o_run=0, o_mode=0 immediately; no tx_start after reset release.
